// File: rtl/mdu_issue_ctrl.sv
// Execute-stage front end for the multi-cycle mul/div unit: captures one op, resolves
// divide corner cases locally, otherwise issues to the unit and holds the result for EX/MEM.
module mdu_issue_ctrl #(
  parameter int XLEN     = 64,
  parameter int RD_W     = 5,
  parameter int WAIT_MAX = 127
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_type,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [RD_W-1:0] in_rd,
  output logic            mdu_valid,
  output logic [3:0]      mdu_type,
  output logic [XLEN-1:0] mdu_a,
  output logic [XLEN-1:0] mdu_b,
  output logic            mdu_flush,
  input  logic [XLEN-1:0] mdu_c,
  input  logic            mdu_ok,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            stall_req,
  output logic            wd_err
);

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_MULW  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_REM   = 4'd4;
  localparam logic [3:0] OP_REMU  = 4'd5;
  localparam logic [3:0] OP_DIVW  = 4'd6;
  localparam logic [3:0] OP_DIVUW = 4'd7;
  localparam logic [3:0] OP_REMW  = 4'd8;
  localparam logic [3:0] OP_REMUW = 4'd9;

  localparam int WD_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [3:0]        type_q, type_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

  logic              special;
  logic [XLEN-1:0]   special_res;
  logic [31:0]       a32;
  logic [31:0]       b32;
  logic              b_zero64;
  logic              b_zero32;
  logic              ovf64;
  logic              ovf32;
  logic              handshake;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  function automatic logic is_word(input logic [3:0] t);
    return (t == OP_MULW) || (t == OP_DIVW) || (t == OP_DIVUW) ||
           (t == OP_REMW) || (t == OP_REMUW);
  endfunction

  // Divide-by-zero and signed-overflow results, computed straight from the ID/EX operands.
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    a32         = in_a[31:0];
    b32         = in_b[31:0];
    b_zero64    = (in_b == '0);
    b_zero32    = (b32 == 32'h0000_0000);
    ovf64       = (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1);
    ovf32       = (a32 == 32'h8000_0000) && (b32 == 32'hFFFF_FFFF);
    case (in_type)
      OP_DIV: begin
        if (b_zero64) begin
          special     = 1'b1;
          special_res = '1;
        end else if (ovf64) begin
          special     = 1'b1;
          special_res = in_a;
        end
      end
      OP_DIVU: begin
        if (b_zero64) begin
          special     = 1'b1;
          special_res = '1;
        end
      end
      OP_REM: begin
        if (b_zero64) begin
          special     = 1'b1;
          special_res = in_a;
        end else if (ovf64) begin
          special     = 1'b1;
          special_res = '0;
        end
      end
      OP_REMU: begin
        if (b_zero64) begin
          special     = 1'b1;
          special_res = in_a;
        end
      end
      OP_DIVW: begin
        if (b_zero32) begin
          special     = 1'b1;
          special_res = '1;
        end else if (ovf32) begin
          special     = 1'b1;
          special_res = sext32(32'h8000_0000);
        end
      end
      OP_DIVUW: begin
        if (b_zero32) begin
          special     = 1'b1;
          special_res = '1;
        end
      end
      OP_REMW: begin
        if (b_zero32) begin
          special     = 1'b1;
          special_res = sext32(a32);
        end else if (ovf32) begin
          special     = 1'b1;
          special_res = '0;
        end
      end
      OP_REMUW: begin
        if (b_zero32) begin
          special     = 1'b1;
          special_res = sext32(a32);
        end
      end
      default: begin
        special     = 1'b0;
        special_res = '0;
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    type_d    = type_q;
    rd_d      = rd_q;
    res_d     = res_q;
    wd_cnt_d  = wd_cnt_q;
    in_ready  = (state_q == S_IDLE) && !flush;
    mdu_valid = 1'b0;
    wd_err    = 1'b0;
    mdu_flush = flush;
    handshake = (state_q == S_HOLD) && out_ready;

    // flush wins over every other event, including an accept or a completing handshake.
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_d    = in_a;
            b_d    = in_b;
            type_d = in_type;
            rd_d   = in_rd;
            if (special) begin
              res_d   = special_res;
              state_d = S_HOLD;
            end else begin
              state_d = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          mdu_valid = 1'b1;
          wd_cnt_d  = '0;
          state_d   = S_WAIT;
        end
        S_WAIT: begin
          if (mdu_ok) begin
            res_d   = is_word(type_q) ? sext32(mdu_c[31:0]) : mdu_c;
            state_d = S_HOLD;
          end else if (wd_cnt_q == WD_W'(WAIT_MAX)) begin
            wd_err    = 1'b1;
            mdu_flush = 1'b1;
            state_d   = S_IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      type_q   <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      type_q   <= type_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign mdu_type  = type_q;
  assign mdu_a     = a_q;
  assign mdu_b     = b_q;
  assign out_valid = (state_q == S_HOLD);
  assign out_data  = res_q;
  assign out_rd    = rd_q;
  // Stall drops in the handshake cycle so the upstream op can advance alongside the result.
  assign stall_req = ((state_q != S_IDLE) && !handshake) || (in_valid && !in_ready);

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: directed ops push expected results, a monitor pops them
// on each out_valid/out_ready handshake; a small unit model answers issued ops.
module tb_mdu_issue_ctrl;

  localparam logic [3:0] OP_MUL   = 4'd0;
  localparam logic [3:0] OP_MULW  = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_REM   = 4'd4;
  localparam logic [3:0] OP_REMU  = 4'd5;
  localparam logic [3:0] OP_DIVW  = 4'd6;
  localparam logic [3:0] OP_REMW  = 4'd8;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [3:0]  in_type, mdu_type;
  logic [63:0] in_a, in_b, mdu_a, mdu_b, mdu_c, out_data;
  logic [4:0]  in_rd, out_rd;
  logic        mdu_valid, mdu_flush, mdu_ok, out_valid, out_ready, stall_req, wd_err;

  mdu_issue_ctrl #(.XLEN(64), .RD_W(5), .WAIT_MAX(127)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .mdu_valid(mdu_valid), .mdu_type(mdu_type), .mdu_a(mdu_a), .mdu_b(mdu_b),
    .mdu_flush(mdu_flush), .mdu_c(mdu_c), .mdu_ok(mdu_ok),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .stall_req(stall_req), .wd_err(wd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  rd;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int failures = 0;

  int mv_count = 0;
  int mv_cyc = 0;
  int wd_count = 0;

  int          unit_lat = 3;
  logic [63:0] unit_res = 64'h0;
  bit          unit_hang = 1'b0;
  int          unit_cnt = 0;

  int t0, mv0, wd0, n;
  bit flag_ok, flag_ok2;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Unit model: answers each issue after unit_lat WAIT cycles; deliberately ignores mdu_flush
  // so a late completion can be presented to an already-flushed controller.
  initial begin
    mdu_ok = 1'b0;
    mdu_c  = 64'h0;
    forever begin
      @(negedge clk);
      mdu_ok = 1'b0;
      if (unit_cnt > 0) begin
        unit_cnt--;
        if (unit_cnt == 0) begin
          mdu_ok = 1'b1;
          mdu_c  = unit_res;
        end
      end
      if (mdu_valid === 1'b1 && !unit_hang) unit_cnt = unit_lat;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mdu_valid === 1'b1) begin
        mv_count++;
        mv_cyc = cyc;
      end
      if (wd_err === 1'b1) wd_count++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        exp_t e;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_result: got 0x%0h, expected no result", out_data);
        end else begin
          e = exp_q.pop_front();
          checkOutput("result_data", out_data, e.data);
          checkOutput("result_rd", 64'(out_rd), 64'(e.rd));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic applyStimulus(input logic [3:0] t, input logic [63:0] a, input logic [63:0] b,
                               input logic [4:0] rd, input logic [63:0] exp_data,
                               input bit expect_out, output int acc_cyc);
    int   k;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_type  = t;
    in_a     = a;
    in_b     = b;
    in_rd    = rd;
    k = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && k < 300) begin
      @(negedge clk);
      k++;
    end
    acc_cyc = cyc;
    if (in_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: got in_ready=%b, expected 1", in_ready);
    end else if (expect_out) begin
      e.data = exp_data;
      e.rd   = rd;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic runSpecial(input string name, input logic [3:0] t, input logic [63:0] a,
                            input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp_data);
    int acc, m0;
    m0 = mv_count;
    applyStimulus(t, a, b, rd, exp_data, 1'b1, acc);
    @(negedge clk);
    checkOutput({name, "_valid_at_T+1"}, 64'(out_valid), 64'd1);
    @(negedge clk);
    checkOutput({name, "_no_issue"}, 64'(mv_count - m0), 64'd0);
  endtask

  task automatic runNormal(input string name, input logic [3:0] t, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd, input int lat,
                           input logic [63:0] res, input logic [63:0] exp_data);
    int acc, m0, k;
    m0       = mv_count;
    unit_lat = lat;
    unit_res = res;
    applyStimulus(t, a, b, rd, exp_data, 1'b1, acc);
    k = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    checkOutput({name, "_issue_pulses"}, 64'(mv_count - m0), 64'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_type = 4'd0;
    in_a = 64'h0; in_b = 64'h0; in_rd = 5'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_mdu_valid", 64'(mdu_valid), 64'd0);
    checkOutput("reset_stall", 64'(stall_req), 64'd0);
    checkOutput("reset_out_data", out_data, 64'h0);
    checkOutput("reset_mdu_a", mdu_a, 64'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] MUL 7 * -3 with 3-cycle unit latency");
    mv0 = mv_count;
    unit_lat = 3;
    unit_res = 64'hFFFF_FFFF_FFFF_FFEB;
    applyStimulus(OP_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, 1'b1, t0);
    flag_ok = 1'b1;
    n = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && n < 50) begin
      if (stall_req !== 1'b1) flag_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    checkOutput("mul_stall_busy", 64'(flag_ok), 64'd1);
    checkOutput("mul_issue_pulses", 64'(mv_count - mv0), 64'd1);
    checkOutput("mul_issue_cycle", 64'(mv_cyc), 64'(t0 + 1));
    checkOutput("mul_out_latency", 64'(cyc), 64'(t0 + 5));
    checkOutput("mul_stall_release", 64'(stall_req), 64'd0);
    checkOutput("mul_mdu_a", mdu_a, 64'd7);
    checkOutput("mul_mdu_b", mdu_b, 64'hFFFF_FFFF_FFFF_FFFD);
    checkOutput("mul_mdu_type", 64'(mdu_type), 64'(OP_MUL));
    @(negedge clk);

    $display("[TB] divide corner cases resolved without issue");
    runSpecial("divw_ovf", OP_DIVW, 64'h0000_0000_8000_0000, ONES, 5'd6, 64'hFFFF_FFFF_8000_0000);
    runSpecial("remu_zero", OP_REMU, 64'h1234, 64'h0, 5'd7, 64'h1234);
    runSpecial("div_ovf", OP_DIV, 64'h8000_0000_0000_0000, ONES, 5'd8, 64'h8000_0000_0000_0000);
    runSpecial("rem_ovf", OP_REM, 64'h8000_0000_0000_0000, ONES, 5'd10, 64'h0);
    runSpecial("remw_zero", OP_REMW, 64'h0000_0001_FFFF_FFF0, 64'hFFFF_FFFF_0000_0000, 5'd11,
               64'hFFFF_FFFF_FFFF_FFF0);

    $display("[TB] normal ops: word sign extension and non-zero 64-bit divisor");
    runNormal("mulw", OP_MULW, 64'h1_0000, 64'h8000, 5'd12, 2, 64'h0000_0000_8000_0000,
              64'hFFFF_FFFF_8000_0000);
    runNormal("div_hi_b", OP_DIV, 64'd10, 64'h0000_0001_0000_0000, 5'd13, 4, 64'h0, 64'h0);

    $display("[TB] flush during WAIT");
    mv0 = mv_count;
    unit_lat = 12;
    unit_res = 64'd14;
    applyStimulus(OP_DIV, 64'd100, 64'd7, 5'd14, 64'h0, 1'b0, t0);
    while (cyc < t0 + 11) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_mdu_flush", 64'(mdu_flush), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle", 64'(in_ready), 64'd1);
    flag_ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid !== 1'b0) flag_ok = 1'b0;
    end
    checkOutput("flush_no_out_valid", 64'(flag_ok), 64'd1);
    checkOutput("flush_issue_pulses", 64'(mv_count - mv0), 64'd1);

    $display("[TB] result held under backpressure");
    out_ready = 1'b0;
    applyStimulus(OP_DIVU, 64'd5, 64'h0, 5'd9, ONES, 1'b1, t0);
    @(negedge clk);
    flag_ok = 1'b1;
    flag_ok2 = 1'b1;
    repeat (5) begin
      if (out_valid !== 1'b1 || out_data !== ONES || out_rd !== 5'd9) flag_ok = 1'b0;
      if (stall_req !== 1'b1) flag_ok2 = 1'b0;
      @(negedge clk);
    end
    checkOutput("bp_data_stable", 64'(flag_ok), 64'd1);
    checkOutput("bp_stall_held", 64'(flag_ok2), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_stall_release", 64'(stall_req), 64'd0);
    @(negedge clk);
    checkOutput("bp_in_ready", 64'(in_ready), 64'd1);
    checkOutput("bp_out_valid_low", 64'(out_valid), 64'd0);

    $display("[TB] watchdog expiry with the unit hung");
    unit_hang = 1'b1;
    wd0 = wd_count;
    applyStimulus(OP_MUL, 64'd1, 64'd1, 5'd3, 64'h0, 1'b0, t0);
    n = 0;
    @(negedge clk);
    while (wd_err !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wd_mdu_flush", 64'(mdu_flush), 64'd1);
    checkOutput("wd_cycle", 64'(cyc - mv_cyc), 64'd128);
    @(negedge clk);
    checkOutput("wd_pulse_count", 64'(wd_count - wd0), 64'd1);
    checkOutput("wd_idle", 64'(in_ready), 64'd1);
    checkOutput("wd_no_out_valid", 64'(out_valid), 64'd0);
    unit_hang = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
